// File: rtl/pipe_divider_if.sv
// Handshake bus for pipe_divider: dividend/divisor request side and quotient/remainder result side.
interface pipe_divider_if #(
  parameter int unsigned WIDTH = 8
);
  logic                   in_valid;
  logic                   in_ready;
  logic [2*WIDTH-1:0]     dividend;
  logic [WIDTH-1:0]       divisor;
  logic                   out_valid;
  logic                   out_ready;
  logic [2*WIDTH-1:0]     quotient;
  logic [WIDTH-1:0]       remainder;
  logic                   div_by_zero;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/pipe_divider.sv
// Multi-cycle restoring divider: one quotient bit per CALC cycle, result held in DONE until taken.
module pipe_divider #(
  parameter int unsigned WIDTH = 8
) (
  input  logic            clk,
  input  logic            rst,
  pipe_divider_if.slave   bus
);
  localparam int unsigned QW = 2 * WIDTH;
  localparam int unsigned RW = WIDTH + 1;
  localparam int unsigned CW = $clog2(QW + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t            state;
  state_t            state_next;
  logic [QW-1:0]     q_reg;
  logic [RW-1:0]     rem_reg;
  logic [WIDTH-1:0]  dvsr;
  logic [CW-1:0]     cnt;

  logic              accept_c;
  logic              step_c;
  logic              last_c;
  logic [RW-1:0]     t_c;
  logic [RW-1:0]     rem_step_c;
  logic              ge_c;
  logic [QW-1:0]     q_step_c;

  logic              in_ready_r;
  logic              out_valid_r;
  logic [QW-1:0]     quotient_r;
  logic [WIDTH-1:0]  remainder_r;
  logic              dbz_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.in_valid) state_next = (bus.divisor == '0) ? DONE : CALC;
      CALC:    if (cnt == CW'(1)) state_next = DONE;
      DONE:    if (bus.out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    accept_c = 1'b0;
    step_c   = 1'b0;
    last_c   = 1'b0;
    case (state)
      IDLE: accept_c = bus.in_valid;
      CALC: begin
        step_c = 1'b1;
        last_c = (cnt == CW'(1));
      end
      default: ;
    endcase
  end

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    t_c        = RW'({rem_reg, q_reg[QW-1]});
    ge_c       = (t_c >= RW'(dvsr));
    rem_step_c = ge_c ? (t_c - RW'(dvsr)) : t_c;
    q_step_c   = {q_reg[QW-2:0], ge_c};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_reg   <= '0;
      rem_reg <= '0;
      dvsr    <= '0;
      cnt     <= '0;
    end else if (accept_c) begin
      q_reg   <= bus.dividend;
      rem_reg <= '0;
      dvsr    <= bus.divisor;
      cnt     <= CW'(QW);
    end else if (step_c) begin
      q_reg   <= q_step_c;
      rem_reg <= rem_step_c;
      cnt     <= cnt - CW'(1);
    end
  end

  // Result registers only change on a zero-divisor accept or on the final step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      quotient_r  <= '0;
      remainder_r <= '0;
      dbz_r       <= 1'b0;
    end else begin
      in_ready_r  <= (state_next == IDLE);
      out_valid_r <= (state_next == DONE);
      if (accept_c && (bus.divisor == '0)) begin
        quotient_r  <= '1;
        remainder_r <= bus.dividend[WIDTH-1:0];
        dbz_r       <= 1'b1;
      end else if (last_c) begin
        quotient_r  <= q_step_c;
        remainder_r <= WIDTH'(rem_step_c);
        dbz_r       <= 1'b0;
      end
    end
  end

  assign bus.in_ready    = in_ready_r;
  assign bus.out_valid   = out_valid_r;
  assign bus.quotient    = quotient_r;
  assign bus.remainder   = remainder_r;
  assign bus.div_by_zero = dbz_r;
endmodule

// File: tb/tb_pipe_divider.sv
// Scoreboard bench for pipe_divider: expected results queued at accept, checked when out_valid appears.
module tb_pipe_divider;
  localparam int unsigned W  = 8;
  localparam int unsigned QW = 2 * W;

  typedef struct packed {
    logic [QW-1:0] q;
    logic [W-1:0]  r;
    logic          z;
  } res_t;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;
  res_t sb[$];

  pipe_divider_if #(.WIDTH(W)) bus ();

  pipe_divider #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic res_t ref_div(input logic [QW-1:0] dd, input logic [W-1:0] dv);
    res_t r;
    if (dv == '0) begin
      r.q = '1;
      r.r = dd[W-1:0];
      r.z = 1'b1;
    end else begin
      r.q = dd / QW'(dv);
      r.r = W'(dd % QW'(dv));
      r.z = 1'b0;
    end
    return r;
  endfunction

  // Present one operation in IDLE; returns just after the accept edge.
  task automatic issue(input logic [QW-1:0] dd, input logic [W-1:0] dv);
    int guard = 0;
    @(negedge clk);
    while (!bus.in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) begin
      n_vec++; n_err++;
      $display("FAIL issue_wait: in_ready stuck at %b, want 1", bus.in_ready);
    end
    bus.dividend = dd;
    bus.divisor  = dv;
    bus.in_valid = 1'b1;
    @(posedge clk);
    sb.push_back(ref_div(dd, dv));
    #1 bus.in_valid = 1'b0;
  endtask

  // Counts edges (accept edge = 1) until out_valid, bounded.
  task automatic drain(output int n);
    n = 1;
    while (!bus.out_valid && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  function automatic res_t pop_exp();
    res_t e = '0;
    if (sb.size() > 0) e = sb.pop_front();
    return e;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    #1;
    n_vec++;
    if ({bus.out_valid, bus.quotient, bus.remainder, bus.div_by_zero} !== '0) begin
      n_err++;
      $display("FAIL reset_hold: got v=%b q=%h r=%h z=%b, want all 0",
               bus.out_valid, bus.quotient, bus.remainder, bus.div_by_zero);
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    n_vec++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.quotient !== '0 ||
        bus.remainder !== '0 || bus.div_by_zero !== 1'b0) begin
      n_err++;
      $display("FAIL reset_release: got rdy=%b v=%b q=%h r=%h z=%b, want rdy=1 rest 0",
               bus.in_ready, bus.out_valid, bus.quotient, bus.remainder, bus.div_by_zero);
    end
  endtask

  task automatic test_basic();
    int n;
    res_t e;
    issue(16'd100, 8'd7);
    drain(n);
    e = pop_exp();
    n_vec++;
    if (n !== 17) begin
      n_err++;
      $display("FAIL basic_latency: got %0d edges, want 17", n);
    end
    n_vec++;
    if ({bus.out_valid, bus.quotient, bus.remainder, bus.div_by_zero} !== {1'b1, e}) begin
      n_err++;
      $display("FAIL basic_result: got v=%b q=%h r=%h z=%b, want q=%h r=%h z=%b",
               bus.out_valid, bus.quotient, bus.remainder, bus.div_by_zero, e.q, e.r, e.z);
    end
    @(posedge clk);
    #1;
    n_vec++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL basic_release: got rdy=%b v=%b, want rdy=1 v=0", bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_extremes();
    logic [QW-1:0] dd [4];
    logic [W-1:0]  dv [4];
    int n;
    res_t e;
    dd[0] = 16'd350;  dv[0] = 8'd7;
    dd[1] = 16'hFFFF; dv[1] = 8'hFF;
    dd[2] = 16'hFFFF; dv[2] = 8'd1;
    dd[3] = 16'd5;    dv[3] = 8'd9;
    for (int i = 0; i < 4; i++) begin
      issue(dd[i], dv[i]);
      drain(n);
      e = pop_exp();
      n_vec++;
      if (n !== 17 || {bus.out_valid, bus.quotient, bus.remainder, bus.div_by_zero} !== {1'b1, e}) begin
        n_err++;
        $display("FAIL extreme_%0d: got n=%0d q=%h r=%h z=%b, want n=17 q=%h r=%h z=%b",
                 i, n, bus.quotient, bus.remainder, bus.div_by_zero, e.q, e.r, e.z);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_div_zero();
    int n;
    res_t e;
    issue(16'h1234, 8'd0);
    drain(n);
    e = pop_exp();
    n_vec++;
    if (n !== 1 || {bus.out_valid, bus.quotient, bus.remainder, bus.div_by_zero} !== {1'b1, e}) begin
      n_err++;
      $display("FAIL dbz_result: got n=%0d q=%h r=%h z=%b, want n=1 q=%h r=%h z=%b",
               n, bus.quotient, bus.remainder, bus.div_by_zero, e.q, e.r, e.z);
    end
    @(posedge clk);
    #1;
    issue(16'd100, 8'd7);
    drain(n);
    e = pop_exp();
    n_vec++;
    if ({bus.out_valid, bus.quotient, bus.remainder, bus.div_by_zero} !== {1'b1, e}) begin
      n_err++;
      $display("FAIL dbz_next: got q=%h r=%h z=%b, want q=%h r=%h z=%b",
               bus.quotient, bus.remainder, bus.div_by_zero, e.q, e.r, e.z);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_ignored_inputs();
    int n;
    res_t e;
    issue(16'd100, 8'd7);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.dividend = 16'd9 + 16'(i);
      bus.divisor  = 8'd3;
      n_vec++;
      if (bus.in_ready !== 1'b0) begin
        n_err++;
        $display("FAIL calc_ready_%0d: got in_ready=%b, want 0", i, bus.in_ready);
      end
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.dividend = '0;
    drain(n);
    e = pop_exp();
    n_vec++;
    if ({bus.out_valid, bus.quotient, bus.remainder, bus.div_by_zero} !== {1'b1, e}) begin
      n_err++;
      $display("FAIL ignored_result: got v=%b q=%h r=%h z=%b, want q=%h r=%h z=%b",
               bus.out_valid, bus.quotient, bus.remainder, bus.div_by_zero, e.q, e.r, e.z);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_pressure();
    int n;
    res_t e;
    bus.out_ready = 1'b0;
    issue(16'd100, 8'd7);
    drain(n);
    e = pop_exp();
    for (int i = 0; i < 5; i++) begin
      n_vec++;
      if ({bus.out_valid, bus.in_ready, bus.quotient, bus.remainder, bus.div_by_zero} !== {2'b10, e}) begin
        n_err++;
        $display("FAIL stall_%0d: got v=%b rdy=%b q=%h r=%h, want v=1 rdy=0 q=%h r=%h",
                 i, bus.out_valid, bus.in_ready, bus.quotient, bus.remainder, e.q, e.r);
      end
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    n_vec++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL stall_release: got v=%b rdy=%b, want v=0 rdy=1", bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    res_t e;
    issue(16'd200, 8'd9);
    repeat (6) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    n_vec++;
    if (bus.out_valid !== 1'b0 || bus.quotient !== '0 || bus.remainder !== '0) begin
      n_err++;
      $display("FAIL midreset_clear: got v=%b q=%h r=%h, want 0 0 0",
               bus.out_valid, bus.quotient, bus.remainder);
    end
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_vec++;
    if (bus.in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL midreset_ready: got in_ready=%b, want 1", bus.in_ready);
    end
    issue(16'd200, 8'd9);
    drain(n);
    e = pop_exp();
    n_vec++;
    if (n !== 17 || {bus.out_valid, bus.quotient, bus.remainder, bus.div_by_zero} !== {1'b1, e}) begin
      n_err++;
      $display("FAIL midreset_redo: got n=%0d q=%h r=%h z=%b, want n=17 q=%h r=%h z=%b",
               n, bus.quotient, bus.remainder, bus.div_by_zero, e.q, e.r, e.z);
    end
    @(posedge clk);
    #1;
  endtask

  // Random operands, random consumer stalls, and in_valid noise while busy.
  task automatic test_random();
    logic [QW-1:0] dd;
    logic [W-1:0]  dv;
    res_t e;
    int   guard;
    bit   done;
    for (int k = 0; k < 1500; k++) begin
      dd = QW'($urandom);
      dv = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      issue(dd, dv);
      guard = 0;
      done  = 1'b0;
      while (!done && guard < 300) begin
        @(negedge clk);
        guard++;
        bus.out_ready = ($urandom_range(0, 3) != 0);
        bus.in_valid  = $urandom_range(0, 1) != 0;
        bus.dividend  = QW'($urandom);
        bus.divisor   = W'($urandom);
        if (bus.out_valid && sb.size() > 0) begin
          e = sb[0];
          n_vec++;
          if ({bus.quotient, bus.remainder, bus.div_by_zero} !== e) begin
            n_err++;
            $display("FAIL rand_%0d: %h/%h got q=%h r=%h z=%b, want q=%h r=%h z=%b",
                     k, dd, dv, bus.quotient, bus.remainder, bus.div_by_zero, e.q, e.r, e.z);
          end
          if (bus.out_ready) begin
            void'(pop_exp());
            done = 1'b1;
          end
        end
      end
      @(posedge clk);
      #1;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      n_vec++;
      if (!done || bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
        n_err++;
        $display("FAIL rand_end_%0d: done=%b rdy=%b v=%b, want done=1 rdy=1 v=0",
                 k, done, bus.in_ready, bus.out_valid);
      end
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    bus.out_ready = 1'b1;
    test_reset();
    test_basic();
    test_extremes();
    test_div_zero();
    test_ignored_inputs();
    test_back_pressure();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
